// File: rtl/ucie_ctl_phy_sb_pkg.sv
// Shared types and defaults for the PHY sideband config-channel arbiter.
//   sb_arb_states_e : arbiter FSM encoding
//   SB_MAX_CRD      : default credits advertised by the Adapter
//   SB_DEF_NC       : default sideband config beat width
//   sb_id_w()       : grant-index width for a given source count (min 1)
package ucie_ctl_phy_sb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SEND     = 2'b01,
    WAIT_CRD = 2'b10
  } sb_arb_states_e;

  localparam int unsigned SB_MAX_CRD = 4;
  localparam int unsigned SB_DEF_NC  = 32;

  function automatic int unsigned sb_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ucie_ctl_phy_sb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping modulo NUM_SRC.
//   req     in  NUM_SRC  request vector
//   ptr     in  ID_W     round-robin start index
//   gnt_id  out ID_W     selected index (0 when nothing requests)
//   gnt_vld out 1        a requester was found
module ucie_ctl_phy_sb_rr_arbiter
  import ucie_ctl_phy_sb_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 3,
  localparam int unsigned ID_W    = sb_id_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  // Two passes instead of a modulo index: upper segment [ptr..N-1] first,
  // then the wrapped segment [0..ptr-1].
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (!gnt_vld && req[j] && (j >= 32'(ptr))) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (!gnt_vld && req[j] && (j < 32'(ptr))) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_phy_sb_cfg_arbiter.sv
// Shares the RDI sideband config channel between NUM_SRC message sources.
// Round-robin at message granularity, one Adapter credit per beat.
//   i_clk, i_rst_n       clock, async active-low reset
//   i_src_req/data/last  per-source beat valid, data ([k*NC +: NC]), last
//   o_src_ack            beat accepted this cycle (combinational, one-hot/0)
//   i_rdi_lp_cfg_crd     credit return pulse
//   o_rdi_pl_cfg_vld/cfg registered beat to the Adapter
//   o_grant_id, o_busy   current owner, FSM not idle
//   o_crd_cnt, o_crd_err available credits, sticky overflow
module ucie_ctl_phy_sb_cfg_arbiter
  import ucie_ctl_phy_sb_pkg::*;
#(
  parameter  int unsigned NC      = SB_DEF_NC,
  parameter  int unsigned NUM_SRC = 3,
  parameter  int unsigned MAX_CRD = SB_MAX_CRD,
  localparam int unsigned CRD_W   = $clog2(MAX_CRD + 1),
  localparam int unsigned ID_W    = sb_id_w(NUM_SRC)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_SRC-1:0]    i_src_req,
  input  logic [NUM_SRC*NC-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]    i_src_last,
  output logic [NUM_SRC-1:0]    o_src_ack,
  input  logic                  i_rdi_lp_cfg_crd,
  output logic                  o_rdi_pl_cfg_vld,
  output logic [NC-1:0]         o_rdi_pl_cfg,
  output logic [ID_W-1:0]       o_grant_id,
  output logic                  o_busy,
  output logic [CRD_W-1:0]      o_crd_cnt,
  output logic                  o_crd_err
);

  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(MAX_CRD);
  localparam logic [ID_W-1:0]  LAST_SRC = ID_W'(NUM_SRC - 1);

  sb_arb_states_e   state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CRD_W-1:0] crd_q, crd_d;
  logic             err_q, err_d;
  logic             vld_q;
  logic [NC-1:0]    data_q;

  logic [ID_W-1:0]  arb_id;
  logic             arb_vld;
  logic             beat_req;
  logic             beat_last;
  logic [NC-1:0]    beat_data;
  logic             accept;

  ucie_ctl_phy_sb_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .req     (i_src_req),
    .ptr     (ptr_q),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

  // Owner's beat signals selected by compare rather than variable index,
  // so non-power-of-two NUM_SRC never addresses a missing source.
  always_comb begin
    beat_req  = 1'b0;
    beat_last = 1'b0;
    beat_data = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (ID_W'(j) == grant_q) begin
        beat_req  = i_src_req[j];
        beat_last = i_src_last[j];
        beat_data = i_src_data[j*NC +: NC];
      end
    end
  end

  assign accept = (state_q == SEND) && beat_req && (crd_q != '0);

  always_comb begin
    o_src_ack = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      o_src_ack[j] = accept && (ID_W'(j) == grant_q);
    end
  end

  // Credit counter: simultaneous take and return cancel out; a return at
  // full count saturates and flags an error.
  always_comb begin
    crd_d = crd_q;
    err_d = err_q;
    if (i_rdi_lp_cfg_crd && !accept) begin
      if (crd_q == CRD_MAX) begin
        err_d = 1'b1;
      end else begin
        crd_d = crd_q + 1'b1;
      end
    end else if (accept && !i_rdi_lp_cfg_crd) begin
      crd_d = crd_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_id;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (beat_last) begin
            state_d = IDLE;
            ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
          end
        end else if (crd_q == '0) begin
          state_d = WAIT_CRD;
        end
      end
      WAIT_CRD: begin
        // Uses next count so a credit pulse resumes sending next cycle.
        if (crd_d != '0) begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      crd_q   <= CRD_MAX;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      crd_q   <= crd_d;
      err_q   <= err_d;
      vld_q   <= accept;
      data_q  <= accept ? beat_data : '0;
    end
  end

  assign o_rdi_pl_cfg_vld = vld_q;
  assign o_rdi_pl_cfg     = data_q;
  assign o_grant_id       = grant_q;
  assign o_busy           = (state_q != IDLE);
  assign o_crd_cnt        = crd_q;
  assign o_crd_err        = err_q;

endmodule

// File: tb/tb_ucie_ctl_phy_sb_cfg_arbiter.sv
module tb_ucie_ctl_phy_sb_cfg_arbiter;

  logic        clk;
  logic        rst_n;

  logic [2:0]  req;
  logic [95:0] data;
  logic [2:0]  last;
  logic        crd;
  logic [2:0]  ack;
  logic        vld;
  logic [31:0] cfg;
  logic [1:0]  gid;
  logic        busy;
  logic [2:0]  cnt;
  logic        err;

  logic [2:0]  req2;
  logic [95:0] data2;
  logic [2:0]  last2;
  logic        crd2;
  logic [2:0]  ack2;
  logic        vld2;
  logic [31:0] cfg2;
  logic [1:0]  gid2;
  logic        busy2;
  logic [1:0]  cnt2;
  logic        err2;

  int nchk  = 0;
  int npass = 0;

  ucie_ctl_phy_sb_cfg_arbiter #(
    .NC      (32),
    .NUM_SRC (3),
    .MAX_CRD (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_src_req        (req),
    .i_src_data       (data),
    .i_src_last       (last),
    .o_src_ack        (ack),
    .i_rdi_lp_cfg_crd (crd),
    .o_rdi_pl_cfg_vld (vld),
    .o_rdi_pl_cfg     (cfg),
    .o_grant_id       (gid),
    .o_busy           (busy),
    .o_crd_cnt        (cnt),
    .o_crd_err        (err)
  );

  ucie_ctl_phy_sb_cfg_arbiter #(
    .NC      (32),
    .NUM_SRC (3),
    .MAX_CRD (2)
  ) dut2 (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_src_req        (req2),
    .i_src_data       (data2),
    .i_src_last       (last2),
    .o_src_ack        (ack2),
    .i_rdi_lp_cfg_crd (crd2),
    .o_rdi_pl_cfg_vld (vld2),
    .o_rdi_pl_cfg     (cfg2),
    .o_grant_id       (gid2),
    .o_busy           (busy2),
    .o_crd_cnt        (cnt2),
    .o_crd_err        (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk = nchk + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on dut, check everything visible in that cycle, advance.
  task automatic cyc(input string tag, input logic [2:0] r, input logic [2:0] l,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic c, input logic [2:0] e_ack, input logic [1:0] e_gid,
                     input logic e_busy, input logic e_vld, input logic [31:0] e_data,
                     input logic [2:0] e_cnt, input logic e_err);
    req  = r;
    last = l;
    data = {d2, d1, d0};
    crd  = c;
    #1;
    chk({tag, ".ack"},  32'(ack),  32'(e_ack));
    chk({tag, ".gid"},  32'(gid),  32'(e_gid));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".vld"},  32'(vld),  32'(e_vld));
    chk({tag, ".data"}, cfg,       e_data);
    chk({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
    chk({tag, ".err"},  32'(err),  32'(e_err));
    tick();
  endtask

  task automatic cyc2(input string tag, input logic r, input logic l, input logic [31:0] d0,
                      input logic c, input logic e_ack, input logic e_busy,
                      input logic e_vld, input logic [31:0] e_data, input logic [1:0] e_cnt);
    req2  = {2'b00, r};
    last2 = {2'b00, l};
    data2 = {64'h0, d0};
    crd2  = c;
    #1;
    chk({tag, ".ack"},  32'(ack2),  {29'h0, 2'b00, e_ack});
    chk({tag, ".busy"}, 32'(busy2), 32'(e_busy));
    chk({tag, ".vld"},  32'(vld2),  32'(e_vld));
    chk({tag, ".data"}, cfg2,       e_data);
    chk({tag, ".cnt"},  32'(cnt2),  32'(e_cnt));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; last = '0; data = '0; crd = 1'b0;
    req2 = '0; last2 = '0; data2 = '0; crd2 = 1'b0;
    #12;
    chk("rst.vld",  32'(vld),  32'h0);
    chk("rst.data", cfg,       32'h0);
    chk("rst.ack",  32'(ack),  32'h0);
    chk("rst.gid",  32'(gid),  32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.err",  32'(err),  32'h0);
    chk("rst.cnt",  32'(cnt),  32'h4);
    chk("rst.cnt2", 32'(cnt2), 32'h2);
    tick();
    rst_n = 1'b1;

    // Contention: src0 and src2 stream 2-beat messages; credit returned per beat.
    //    tag    req     last    d0     d1  d2     c  ack     gid busy vld data   cnt err
    cyc("c1",  3'b101, 3'b000, 32'h01, 0, 32'h21, 0, 3'b000, 0, 0, 0, 32'h00, 4, 0);
    cyc("c2",  3'b101, 3'b000, 32'h01, 0, 32'h21, 1, 3'b001, 0, 1, 0, 32'h00, 4, 0);
    cyc("c3",  3'b101, 3'b001, 32'h02, 0, 32'h21, 1, 3'b001, 0, 1, 1, 32'h01, 4, 0);
    cyc("c4",  3'b101, 3'b000, 32'h03, 0, 32'h21, 0, 3'b000, 0, 0, 1, 32'h02, 4, 0);
    cyc("c5",  3'b101, 3'b000, 32'h03, 0, 32'h21, 1, 3'b100, 2, 1, 0, 32'h00, 4, 0);
    cyc("c6",  3'b101, 3'b100, 32'h03, 0, 32'h22, 1, 3'b100, 2, 1, 1, 32'h21, 4, 0);
    cyc("c7",  3'b101, 3'b000, 32'h03, 0, 32'h23, 0, 3'b000, 2, 0, 1, 32'h22, 4, 0);
    cyc("c8",  3'b101, 3'b000, 32'h03, 0, 32'h23, 1, 3'b001, 0, 1, 0, 32'h00, 4, 0);
    cyc("c9",  3'b101, 3'b001, 32'h04, 0, 32'h23, 1, 3'b001, 0, 1, 1, 32'h03, 4, 0);
    cyc("c10", 3'b100, 3'b000, 32'h00, 0, 32'h23, 0, 3'b000, 0, 0, 1, 32'h04, 4, 0);
    cyc("c11", 3'b100, 3'b000, 32'h00, 0, 32'h23, 1, 3'b100, 2, 1, 0, 32'h00, 4, 0);
    cyc("c12", 3'b100, 3'b100, 32'h00, 0, 32'h24, 1, 3'b100, 2, 1, 1, 32'h23, 4, 0);
    cyc("c13", 3'b000, 3'b000, 32'h00, 0, 32'h00, 0, 3'b000, 2, 0, 1, 32'h24, 4, 0);
    cyc("c14", 3'b000, 3'b000, 32'h00, 0, 32'h00, 0, 3'b000, 2, 0, 0, 32'h00, 4, 0);

    // Single source, 3 beats, credits 4 -> 1.
    cyc("s1",  3'b001, 3'b000, 32'hA1, 0, 0, 0, 3'b000, 2, 0, 0, 32'h00, 4, 0);
    cyc("s2",  3'b001, 3'b000, 32'hA1, 0, 0, 0, 3'b001, 0, 1, 0, 32'h00, 4, 0);
    cyc("s3",  3'b001, 3'b000, 32'hA2, 0, 0, 0, 3'b001, 0, 1, 1, 32'hA1, 3, 0);
    cyc("s4",  3'b001, 3'b001, 32'hA3, 0, 0, 0, 3'b001, 0, 1, 1, 32'hA2, 2, 0);
    cyc("s5",  3'b000, 3'b000, 32'h00, 0, 0, 0, 3'b000, 0, 0, 1, 32'hA3, 1, 0);
    cyc("s6",  3'b000, 3'b000, 32'h00, 0, 0, 0, 3'b000, 0, 0, 0, 32'h00, 1, 0);

    // Accept and credit pulse together at count 1 (single-beat message).
    cyc("t1",  3'b010, 3'b010, 0, 32'hB1, 0, 0, 3'b000, 0, 0, 0, 32'h00, 1, 0);
    cyc("t2",  3'b010, 3'b010, 0, 32'hB1, 0, 1, 3'b010, 1, 1, 0, 32'h00, 1, 0);
    cyc("t3",  3'b000, 3'b000, 0, 32'h00, 0, 0, 3'b000, 1, 0, 1, 32'hB1, 1, 0);

    // Source bubble mid-message keeps the grant; credits refilled to 4.
    cyc("u1",  3'b010, 3'b000, 0, 32'hC1, 0, 1, 3'b000, 1, 0, 0, 32'h00, 1, 0);
    cyc("u2",  3'b010, 3'b000, 0, 32'hC1, 0, 1, 3'b010, 1, 1, 0, 32'h00, 2, 0);
    cyc("u3",  3'b000, 3'b000, 0, 32'h00, 0, 1, 3'b000, 1, 1, 1, 32'hC1, 2, 0);
    cyc("u4",  3'b010, 3'b010, 0, 32'hC2, 0, 0, 3'b010, 1, 1, 0, 32'h00, 3, 0);
    cyc("u5",  3'b000, 3'b000, 0, 32'h00, 0, 1, 3'b000, 1, 0, 1, 32'hC2, 2, 0);
    cyc("u6",  3'b000, 3'b000, 0, 32'h00, 0, 1, 3'b000, 1, 0, 0, 32'h00, 3, 0);
    cyc("u7",  3'b000, 3'b000, 0, 32'h00, 0, 0, 3'b000, 1, 0, 0, 32'h00, 4, 0);

    // Overflow: pulse at full count saturates and sets the sticky error.
    cyc("o1",  3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 32'h00, 4, 0);
    cyc("o2",  3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0, 32'h00, 4, 1);
    cyc("o3",  3'b000, 3'b000, 0, 0, 0, 1, 3'b000, 1, 0, 0, 32'h00, 4, 1);
    cyc("o4",  3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 1, 0, 0, 32'h00, 4, 1);

    // Reset after the 2nd beat of a 4-beat src1 message (pointer is 2 here).
    cyc("r1",  3'b010, 3'b000, 0, 32'hD1, 0, 0, 3'b000, 1, 0, 0, 32'h00, 4, 1);
    cyc("r2",  3'b010, 3'b000, 0, 32'hD1, 0, 0, 3'b010, 1, 1, 0, 32'h00, 4, 1);
    cyc("r3",  3'b010, 3'b000, 0, 32'hD2, 0, 0, 3'b010, 1, 1, 1, 32'hD1, 3, 1);
    chk("r4.vld", 32'(vld), 32'h1);
    chk("r4.data", cfg, 32'hD2);
    chk("r4.cnt", 32'(cnt), 32'h2);
    rst_n = 1'b0;
    req = '0; last = '0; data = '0;
    #1;
    chk("mrst.vld",  32'(vld),  32'h0);
    chk("mrst.data", cfg,       32'h0);
    chk("mrst.ack",  32'(ack),  32'h0);
    chk("mrst.gid",  32'(gid),  32'h0);
    chk("mrst.busy", 32'(busy), 32'h0);
    chk("mrst.cnt",  32'(cnt),  32'h4);
    chk("mrst.err",  32'(err),  32'h0);
    tick();
    rst_n = 1'b1;

    // Pointer restarts at 0: src1 wins over src2.
    cyc("p1",  3'b110, 3'b110, 0, 32'hE1, 32'hF1, 0, 3'b000, 0, 0, 0, 32'h00, 4, 0);
    cyc("p2",  3'b110, 3'b110, 0, 32'hE1, 32'hF1, 0, 3'b010, 1, 1, 0, 32'h00, 4, 0);
    cyc("p3",  3'b100, 3'b100, 0, 0,      32'hF1, 0, 3'b000, 1, 0, 1, 32'hE1, 3, 0);
    cyc("p4",  3'b100, 3'b100, 0, 0,      32'hF1, 0, 3'b100, 2, 1, 0, 32'h00, 3, 0);
    cyc("p5",  3'b000, 3'b000, 0, 0,      0,      0, 3'b000, 2, 0, 1, 32'hF1, 2, 0);

    // Credit starvation on the 2-credit instance; pulse at w5 -> vld at w7.
    //     tag   r  l  d0      c  ack busy vld data    cnt
    cyc2("w1",  1, 0, 32'h61, 0, 0,  0,   0,  32'h00, 2);
    cyc2("w2",  1, 0, 32'h61, 0, 1,  1,   0,  32'h00, 2);
    cyc2("w3",  1, 0, 32'h62, 0, 1,  1,   1,  32'h61, 1);
    cyc2("w4",  1, 0, 32'h63, 0, 0,  1,   1,  32'h62, 0);
    cyc2("w5",  1, 0, 32'h63, 1, 0,  1,   0,  32'h00, 0);
    cyc2("w6",  1, 0, 32'h63, 0, 1,  1,   0,  32'h00, 1);
    cyc2("w7",  1, 1, 32'h64, 0, 0,  1,   1,  32'h63, 0);
    cyc2("w8",  1, 1, 32'h64, 1, 0,  1,   0,  32'h00, 0);
    cyc2("w9",  1, 1, 32'h64, 0, 1,  1,   0,  32'h00, 1);
    cyc2("w10", 0, 0, 32'h00, 0, 0,  0,   1,  32'h64, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
